load_store_unit: RTL

//  Byte-addressed load/store front end for the word-organised data memory (128 x 32, write on posedge, read latched on negedge).

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings, FSM states and the lane-offset helper shared by the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_e;

    localparam int unsigned LANE_W = 2;

    // Bit position of byte lane 'lane' inside a little-endian word.
    function automatic logic [4:0] lane_offset(input logic [LANE_W-1:0] lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ext_data_o,
    output logic [31:0] new_word_o
);

    logic [31:0] shiftedWord;
    logic [31:0] laneMask;
    logic [31:0] placedMask;
    logic [31:0] placedData;

    always_comb begin
        shiftedWord = word_i >> lane_offset(lane_i);
        ext_data_o  = word_i;
        laneMask    = 32'hFFFF_FFFF;
        case (size_i)
            SZ_BYTE: begin
                ext_data_o = unsigned_i ? {24'h0, shiftedWord[7:0]}
                                        : {{24{shiftedWord[7]}}, shiftedWord[7:0]};
                laneMask   = 32'h0000_00FF;
            end
            SZ_HALF: begin
                ext_data_o = unsigned_i ? {16'h0, shiftedWord[15:0]}
                                        : {{16{shiftedWord[15]}}, shiftedWord[15:0]};
                laneMask   = 32'h0000_FFFF;
            end
            default: begin
                ext_data_o = word_i;
                laneMask   = 32'hFFFF_FFFF;
            end
        endcase
        // Only the addressed lanes take the new data; the rest keep the old word.
        placedMask = laneMask << lane_offset(lane_i);
        placedData = wdata_i << lane_offset(lane_i);
        new_word_o = (word_i & ~placedMask) | (placedData & placedMask);
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: valid/ready load/store front end for a 128x32 word memory with read-modify-write sub-word stores.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned or reserved-size requests; otherwise they are force-aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WADDR_W = 7,
    parameter int DATA_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [WADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_rdata,
    output logic               resp_error,
    output logic [WADDR_W-1:0] mem_address,
    output logic               mem_read,
    output logic               mem_write,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    state_e             state_q;
    size_e              size_q;
    logic [1:0]         lane_q;
    logic               isUnsigned_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               memRead_q;
    logic               memWrite_q;
    logic [WADDR_W-1:0] memAddress_q;
    logic [DATA_W-1:0]  memWdata_q;
    logic               respValid_q;
    logic [DATA_W-1:0]  respRdata_q;

    size_e              reqSize;
    logic [1:0]         reqLane;
    logic [DATA_W-1:0]  extData;
    logic [DATA_W-1:0]  mergedWord;

    // Normalise the request: force-align the lane and treat the reserved size as a word.
    always_comb begin
        reqSize = SZ_BYTE;
        reqLane = req_addr[1:0];
        case (req_size)
            2'b00: begin
                reqSize = SZ_BYTE;
                reqLane = req_addr[1:0];
            end
            2'b01: begin
                reqSize = SZ_HALF;
                reqLane = {req_addr[1], 1'b0};
            end
            default: begin
                reqSize = SZ_WORD;
                reqLane = 2'b00;
            end
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalignErr;
    logic respError_q;

    assign misalignErr = ((req_size == SZ_HALF) && req_addr[0])
                      || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                      || (req_size == SZ_RSVD);
    assign resp_error  = respError_q;
`else
    assign resp_error  = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .word_i     (mem_rdata),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .unsigned_i (isUnsigned_q),
        .wdata_i    (wdata_q),
        .ext_data_o (extData),
        .new_word_o (mergedWord)
    );

    // Single registered FSM; every mem_* and resp_* output comes straight from a flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            size_q       <= SZ_BYTE;
            lane_q       <= 2'b00;
            isUnsigned_q <= 1'b0;
            wdata_q      <= '0;
            memRead_q    <= 1'b0;
            memWrite_q   <= 1'b0;
            memAddress_q <= '0;
            memWdata_q   <= '0;
            respValid_q  <= 1'b0;
            respRdata_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            respError_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        size_q       <= reqSize;
                        lane_q       <= reqLane;
                        isUnsigned_q <= req_unsigned;
                        wdata_q      <= req_wdata;
                        respRdata_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
                        if (misalignErr) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            respError_q <= 1'b1;
                        end else
`endif
                        begin
                            memAddress_q <= req_addr[WADDR_W+1:2];
                            if (!req_write) begin
                                state_q   <= LOAD;
                                memRead_q <= 1'b1;
                            end else if (reqSize == SZ_WORD) begin
                                state_q    <= WRITE;
                                memWrite_q <= 1'b1;
                                memWdata_q <= req_wdata;
                            end else begin
                                state_q   <= RMW_RD;
                                memRead_q <= 1'b1;
                            end
                        end
                    end
                end
                LOAD: begin
                    memRead_q   <= 1'b0;
                    respRdata_q <= extData;
                    respValid_q <= 1'b1;
                    state_q     <= RESP;
                end
                WRITE: begin
                    memWrite_q  <= 1'b0;
                    respValid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RMW_RD: begin
                    memRead_q  <= 1'b0;
                    memWrite_q <= 1'b1;
                    memWdata_q <= mergedWord;
                    state_q    <= RMW_WR;
                end
                RMW_WR: begin
                    memWrite_q  <= 1'b0;
                    respValid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        respValid_q <= 1'b0;
                        respRdata_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
                        respError_q <= 1'b0;
`endif
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    memRead_q   <= 1'b0;
                    memWrite_q  <= 1'b0;
                    respValid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = respValid_q;
    assign resp_rdata  = respRdata_q;
    assign mem_address = memAddress_q;
    assign mem_read    = memRead_q;
    assign mem_write   = memWrite_q;
    assign mem_wdata   = memWdata_q;

endmodule
